// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - LSU memory responder, one request at a time, fixed latency; optional macro RAND_DELAY_EN adds 0..3 LFSR-driven wait cycles
module mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    // Counter must hold LATENCY-1 plus up to 3 random extra cycles.
    localparam int unsigned CW   = $clog2(LATENCY + 4);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wen_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wmask_q;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic [31:0]    mem_q [DEPTH];

    logic           accept;
    logic           access;
    logic           resp_done;
    logic [31:0]    offset;
    logic           in_range;
    logic [AW-1:0]  idx;
    logic [CW-1:0]  cnt_init;

`ifdef RAND_DELAY_EN
    logic [15:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign cnt_init = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
    assign cnt_init = CW'(LATENCY - 1);
`endif

    assign accept    = (state_q == S_IDLE) && req_valid_i;
    assign access    = (state_q == S_WAIT) && (cnt_q == '0);
    assign resp_done = (state_q == S_RESP) && resp_ready_i;

    // Unsigned wrap makes addresses below BASE land far out of range.
    assign offset   = addr_q - BASE;
    assign in_range = offset < SPAN;
    assign idx      = offset[AW+1:2];

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid_i)   state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0)   state_d = S_RESP;
            S_RESP:  if (resp_ready_i)  state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake signals follow the state directly.
    always_comb begin
        req_ready_o  = (state_q == S_IDLE);
        resp_valid_o = (state_q == S_RESP);
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
    end

    // Wait counter and response data next-state.
    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d = cnt_init;
        end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (access) begin
            err_d   = !in_range;
            rdata_d = (in_range && !wen_q) ? mem_q[idx] : 32'h0;
        end else if (resp_done) begin
            err_d   = 1'b0;
            rdata_d = 32'h0;
        end
    end

    // Request latch, counter and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wen_q   <= req_wen_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wmask_q <= req_wmask_i;
            end
        end
    end

    // Word array; only the store access edge writes, contents survive reset.
    always_ff @(posedge clk_i) begin
        if (access && in_range && wen_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
